// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter with a small byte FIFO.
//   Register window: BASE_ADR+0 DATA (write pushes a byte, reads 0),
//                    BASE_ADR+1 STATUS (read {4'b0, ovf, tx_active, empty, full},
//                    write clears ovf).
//
// Ports
//   clk        system clock (CPU clock), all state on posedge
//   reset      asynchronous, active-high
//   adr_bus    CPU address
//   RW         1 = read, 0 = write (write seen at exactly one posedge)
//   wdata      CPU write data
//   rdata      combinational read data, 0 unless a STATUS read is in progress
//   sel        combinational window decode for the CPU bus mux
//   tx         registered serial output, idles high
//   irq_empty  registered: FIFO empty and transmitter idle
//
// State table
//   S_IDLE  | line idle high, waiting for a queued byte
//   S_START | driving the start bit (low) for CLK_DIV cycles
//   S_DATA  | driving data bits LSB first, CLK_DIV cycles each
//   S_STOP  | driving the stop bit (high); may chain straight into S_START
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADR   = 16'h6000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adr_bus,
  input  logic        RW,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq_empty
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              BW        = $clog2(CLK_DIV);
  localparam logic [15:0]     STAT_ADR  = BASE_ADR + 16'd1;
  localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0]   BCNT_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            irq_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic hit_data, hit_stat;
  logic push_req, push_ok, pop;
  logic fifo_full, fifo_empty, bcnt_end;

  assign hit_data   = (adr_bus == BASE_ADR);
  assign hit_stat   = (adr_bus == STAT_ADR);
  assign sel        = hit_data | hit_stat;
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign bcnt_end   = (bcnt_q == BCNT_LAST);

  // A push into a full FIFO still fits when the FSM pops the head this cycle.
  assign push_req = ~RW & hit_data;
  assign push_ok  = push_req & (~fifo_full | pop);

  always_comb begin
    rdata = 8'h00;
    if (RW && hit_stat)
      rdata = {4'b0000, ovf_q, (state_q != S_IDLE), fifo_empty, fifo_full};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok)
      ovf_d = 1'b1;
    else if (!RW && hit_stat)
      ovf_d = 1'b0;
  end

  // tx_d is the line level for the state being entered, so tx stays a clean flop.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bcnt_d  = '0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bcnt_end) begin
          bcnt_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bcnt_end) begin
          bcnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bcnt_end) begin
          bcnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= fifo_empty && (state_q == S_IDLE);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  // On a full-FIFO collision the pop reads the old head before this write lands.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign tx        = tx_q;
  assign irq_empty = irq_q;

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU's address/data bus, downstream of the CPU core. It consumes CPU write cycles (`adr_bus`, `RW`, CPU data out) aimed at its two-register window, queues bytes in a small FIFO, and serialises them as 8N1 frames on `tx`. It also returns a status byte to the CPU's `data_bus_in` during read cycles.

## Interface
- `BASE_ADR`, default 16'h6000: base of the 2-byte register window (BASE+0 DATA, BASE+1 STATUS).
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, 2..16.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock, same as the CPU. All state updates on posedge.
- `reset` in 1: asynchronous, active-high.
- `adr_bus` in 16: CPU address.
- `RW` in 1: 1 = read, 0 = write.
- `wdata` in 8: CPU write data (CPU `data_bus_out`).
- `rdata` out 8: read data to CPU `data_bus_in`; combinational.
- `sel` out 1: combinational; 1 when `adr_bus` is BASE or BASE+1. Used by the bus mux.
- `tx` out 1: serial line; idles high.
- `irq_empty` out 1: registered; 1 when the FIFO is empty and the FSM is IDLE.

## Operation
- Decode: `hit_data` = (`adr_bus`==BASE_ADR); `hit_stat` = (`adr_bus`==BASE_ADR+1).
- Write capture: at posedge with `RW`=0.
  - A CPU write holds `RW` low for exactly one clock (negedge to negedge), so it is seen at exactly one posedge and produces one action.
- Write to DATA: push `wdata`.
  - Accepted if count < FIFO_DEPTH, or if the FSM pops in the same cycle (count then unchanged).
  - Otherwise the byte is dropped and sticky `ovf` is set.
- Write to STATUS: clears `ovf`; data value is ignored.
- Read (`RW`=1):
  - DATA returns 8'h00.
  - STATUS returns {4'b0, ovf, tx_active, empty, full}: bit0 full (count==FIFO_DEPTH), bit1 empty (count==0), bit2 tx_active (FSM≠IDLE), bit3 ovf.
  - Reads have no side effects.
- `rdata` = 8'h00 whenever `sel`=0 or `RW`=0.
- FIFO: circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, natural wrap) and a count of log2(DEPTH)+1 bits.
- TX FSM, one baud counter `bcnt` counting 0..CLK_DIV-1, plus a bit index 0..7:
  - IDLE: `tx`=1. If count>0: pop head into the shift register, `bcnt`←0, go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first; shift right every CLK_DIV cycles; after bit 7, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end, if count>0, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Pop/push collision: simultaneous push and pop both take effect, and count is unchanged.
- Reset, including mid-frame:
  - FIFO emptied (pointers and count = 0), `ovf`=0, FSM=IDLE, `bcnt`=0.
  - `tx`=1 and `irq_empty`=1 immediately (asynchronous). Any frame in progress is truncated.
- `tx` is a registered output, with no combinational path from the bus.

## Timing
- Write at posedge k into an empty FIFO:
  - Count becomes 1 after k.
  - FSM pops at posedge k+1; `tx` falls after k+1.
  - STATUS empty reads 1 again from after k+1.
- Frame length = 10·CLK_DIV cycles. Start bit begins after posedge P; data bit n begins after P+(1+n)·CLK_DIV; stop bit after P+9·CLK_DIV.
- Back-to-back: the next start bit begins after P+10·CLK_DIV, with no extra cycle.
- `irq_empty` updates one cycle after the condition changes.
- `rdata`/`sel` are valid combinationally within the same cycle as `adr_bus`, before the CPU's sampling negedge.

## Test plan
- Reset (`reset`=1 mid-frame of 8'hA5, DEPTH=4, CLK_DIV=16) → `tx`=1 immediately; STATUS read = 8'h02; `irq_empty`=1.
- Single byte: write 8'h55 to 16'h6000 → `tx` low 16 cycles starting 1 cycle after the write posedge, then bits 1,0,1,0,1,0,1,0 of 16 cycles each, then stop high; `irq_empty` returns to 1 after 160 cycles + 1.
- Burst: 5 consecutive writes 8'h01..8'h05 in idle → first pops immediately, the remaining 4 fill the FIFO (STATUS = 8'h05: full + active); frames go out back-to-back with no idle gap; all 5 bytes are received in order by a bench UART model.
- Overflow: with FIFO full and no pop in that cycle, write 8'hEE → dropped; STATUS bit3 = 1; write any value to 16'h6001 → STATUS bit3 = 0; 8'hEE is never transmitted.
- Collision: write exactly in the STOP-end cycle while full → byte accepted; count stays 4; no `ovf`.
- Decode: reads/writes to 16'h5FFF and 16'h6002 → `sel`=0, `rdata`=8'h00, no FIFO change; read of 16'h6000 → 8'h00.
